// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing for the completion/CDB path: PRF tag width and FU count.
package cdb_arbiter_pkg;

  localparam int unsigned PRF_IDX_W = 7;
  localparam int unsigned NUM_FU    = 4;
  localparam int unsigned FU_IDX_W  = $clog2(NUM_FU);

  typedef logic [PRF_IDX_W-1:0] prf_tag_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N; returns one-hot grant and encoded index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                         req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                         gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic                                 any_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    req2  = {req_i, req_i};
    rot   = req2[ptr_i +: N];
    any_o = 1'b0;
    off   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any_o && rot[j]) begin
        any_o = 1'b1;
        off   = j[IW-1:0];
      end
    end
    // Rotate the winning offset back into absolute FU numbering.
    sum = {1'b0, off} + {1'b0, ptr_i};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx_o = sum[IW-1:0];
    gnt_o = '0;
    for (int unsigned j = 0; j < N; j++) begin
      gnt_o[j] = any_o && (idx_o == j[IW-1:0]);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-CDB completion arbiter: round-robin over FU results, with a
// one-entry holding register per FU that back-pressures losers until granted.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU = cdb_arbiter_pkg::NUM_FU
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_FU-1:0]                    fu_done_vld_i,
  input  logic [NUM_FU-1:0][PRF_IDX_W-1:0]     fu_done_tag_i,
  input  logic                                 flush_i,
  output logic [NUM_FU-1:0]                    fu_stall_o,
  output logic                                 cdb_vld_o,
  output logic [PRF_IDX_W-1:0]                 cdb_tag_o,
  output logic [$clog2(NUM_FU)-1:0]            cdb_fu_idx_o
);

  localparam int unsigned IW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]            hold_vld_q, hold_vld_d;
  prf_tag_t [NUM_FU-1:0]        hold_tag_q, hold_tag_d;
  logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
  logic                         cdb_vld_q, cdb_vld_d;
  prf_tag_t                     cdb_tag_q, cdb_tag_d;
  logic [IW-1:0]                cdb_idx_q, cdb_idx_d;

  logic [NUM_FU-1:0]            cand_vld;
  prf_tag_t [NUM_FU-1:0]        cand_tag;
  logic [NUM_FU-1:0]            gnt;
  logic [IW-1:0]                win_idx;
  logic                         win_any;

  // A held FU is stalled, so its live valid is a protocol violation and ignored.
  always_comb begin
    cand_vld = hold_vld_q | fu_done_vld_i;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      cand_tag[i] = hold_vld_q[i] ? hold_tag_q[i] : fu_done_tag_i[i];
    end
  end

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req_i (cand_vld),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_tag_d = hold_tag_q;
    rr_ptr_d   = rr_ptr_q;
    cdb_vld_d  = 1'b0;
    cdb_tag_d  = '0;
    cdb_idx_d  = '0;
    if (flush_i) begin
      hold_vld_d = '0;
      rr_ptr_d   = '0;
    end else begin
      if (win_any) begin
        cdb_vld_d = 1'b1;
        cdb_tag_d = cand_tag[win_idx];
        cdb_idx_d = win_idx;
        rr_ptr_d  = (win_idx == IW'(NUM_FU-1)) ? '0 : win_idx + IW'(1);
      end
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (gnt[i]) begin
          hold_vld_d[i] = 1'b0;
        end else if (fu_done_vld_i[i] && !hold_vld_q[i]) begin
          hold_vld_d[i] = 1'b1;
          hold_tag_d[i] = fu_done_tag_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q <= '0;
      hold_tag_q <= '0;
      rr_ptr_q   <= '0;
      cdb_vld_q  <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_idx_q  <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_tag_q <= hold_tag_d;
      rr_ptr_q   <= rr_ptr_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_idx_q  <= cdb_idx_d;
    end
  end

  assign fu_stall_o   = hold_vld_q;
  assign cdb_vld_o    = cdb_vld_q;
  assign cdb_tag_o    = cdb_tag_q;
  assign cdb_fu_idx_o = cdb_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, async-reset sequence, and
// randomized traffic against a queue-free per-FU scoreboard model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef logic [3:0][PRF_IDX_W-1:0] tags_t;

  typedef struct {
    logic [3:0]     vld;
    tags_t          tags;
    logic           fl;
    logic           ev;
    prf_tag_t       et;
    logic [1:0]     ei;
    logic [3:0]     es;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  fu_done_vld_i;
  tags_t       fu_done_tag_i;
  logic        flush_i;
  logic [3:0]  fu_stall_o;
  logic        cdb_vld_o;
  prf_tag_t    cdb_tag_o;
  logic [1:0]  cdb_fu_idx_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Scoreboard: per-FU parked result plus the round-robin start point.
  logic [3:0]  m_hold_v;
  tags_t       m_hold_t;
  int          m_ptr;

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fu_done_vld_i (fu_done_vld_i),
    .fu_done_tag_i (fu_done_tag_i),
    .flush_i       (flush_i),
    .fu_stall_o    (fu_stall_o),
    .cdb_vld_o     (cdb_vld_o),
    .cdb_tag_o     (cdb_tag_o),
    .cdb_fu_idx_o  (cdb_fu_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic tags_t tg(input int a, input int b, input int c, input int d);
    tags_t t;
    t[0] = PRF_IDX_W'(a);
    t[1] = PRF_IDX_W'(b);
    t[2] = PRF_IDX_W'(c);
    t[3] = PRF_IDX_W'(d);
    return t;
  endfunction

  task automatic model_reset();
    m_hold_v = '0;
    m_hold_t = '0;
    m_ptr    = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic [3:0] v, input tags_t t, input logic fl);
    logic      e_vld;
    prf_tag_t  e_tag;
    int        e_idx;
    int        win;
    chk("protocol_no_vld_while_stalled", 32'(v & fu_stall_o), 32'd0);
    fu_done_vld_i = v;
    fu_done_tag_i = t;
    flush_i       = fl;
    e_vld = 1'b0;
    e_tag = '0;
    e_idx = 0;
    if (fl) begin
      m_hold_v = '0;
      m_ptr    = 0;
    end else begin
      win = -1;
      for (int n = 0; n < 4; n++) begin
        int k;
        k = (m_ptr + n) % 4;
        if (win < 0 && (m_hold_v[k] || v[k])) win = k;
      end
      if (win >= 0) begin
        e_vld = 1'b1;
        e_tag = m_hold_v[win] ? m_hold_t[win] : t[win];
        e_idx = win;
        m_ptr = (win + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (i == win) m_hold_v[i] = 1'b0;
        else if (!m_hold_v[i] && v[i]) begin
          m_hold_v[i] = 1'b1;
          m_hold_t[i] = t[i];
        end
      end
    end
    @(posedge clk);
    #1;
    chk("cdb_vld", 32'(cdb_vld_o), 32'(e_vld));
    chk("cdb_tag", 32'(cdb_tag_o), 32'(e_tag));
    chk("cdb_idx", 32'(cdb_fu_idx_o), 32'(e_idx));
    chk("fu_stall", 32'(fu_stall_o), 32'(m_hold_v));
    chk("rr_ptr", 32'(dut.rr_ptr_q), 32'(m_ptr));
  endtask

  vec_t tbl[18];

  initial begin
    rst           = 1'b1;
    fu_done_vld_i = '0;
    fu_done_tag_i = '0;
    flush_i       = 1'b0;
    model_reset();

    // Directed vectors starting from reset (rr_ptr = 0).
    tbl[0]  = '{4'b0001, tg(12,0,0,0),   1'b0, 1'b1, 7'd12, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b0, 7'd0,  2'd0, 4'b0000};
    tbl[2]  = '{4'b0000, tg(0,0,0,0),    1'b1, 1'b0, 7'd0,  2'd0, 4'b0000};
    tbl[3]  = '{4'b1111, tg(10,11,12,13),1'b0, 1'b1, 7'd10, 2'd0, 4'b1110};
    tbl[4]  = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b1, 7'd11, 2'd1, 4'b1100};
    tbl[5]  = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b1, 7'd12, 2'd2, 4'b1000};
    tbl[6]  = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b1, 7'd13, 2'd3, 4'b0000};
    tbl[7]  = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b0, 7'd0,  2'd0, 4'b0000};
    tbl[8]  = '{4'b0101, tg(20,0,22,0),  1'b0, 1'b1, 7'd20, 2'd0, 4'b0100};
    tbl[9]  = '{4'b0001, tg(21,0,0,0),   1'b0, 1'b1, 7'd22, 2'd2, 4'b0001};
    tbl[10] = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b1, 7'd21, 2'd0, 4'b0000};
    tbl[11] = '{4'b0000, tg(0,0,0,0),    1'b1, 1'b0, 7'd0,  2'd0, 4'b0000};
    tbl[12] = '{4'b0111, tg(40,41,42,0), 1'b0, 1'b1, 7'd40, 2'd0, 4'b0110};
    tbl[13] = '{4'b0000, tg(0,0,0,0),    1'b1, 1'b0, 7'd0,  2'd0, 4'b0000};
    tbl[14] = '{4'b1001, tg(50,0,0,53),  1'b0, 1'b1, 7'd50, 2'd0, 4'b1000};
    tbl[15] = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b1, 7'd53, 2'd3, 4'b0000};
    tbl[16] = '{4'b0010, tg(0,60,0,0),   1'b1, 1'b0, 7'd0,  2'd0, 4'b0000};
    tbl[17] = '{4'b0000, tg(0,0,0,0),    1'b0, 1'b0, 7'd0,  2'd0, 4'b0000};

    #3;
    chk("reset_cdb_vld", 32'(cdb_vld_o), 32'd0);
    chk("reset_cdb_tag", 32'(cdb_tag_o), 32'd0);
    chk("reset_cdb_idx", 32'(cdb_fu_idx_o), 32'd0);
    chk("reset_stall", 32'(fu_stall_o), 32'd0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].vld, tbl[i].tags, tbl[i].fl);
      chk($sformatf("tbl%0d_vld", i), 32'(cdb_vld_o), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_tag", i), 32'(cdb_tag_o), 32'(tbl[i].et));
      chk($sformatf("tbl%0d_idx", i), 32'(cdb_fu_idx_o), 32'(tbl[i].ei));
      chk($sformatf("tbl%0d_stall", i), 32'(fu_stall_o), 32'(tbl[i].es));
    end

    // Async reset in the middle of a cycle with three results parked.
    step(4'b1111, tg(70,71,72,73), 1'b0);
    chk("pre_rst_stall", 32'(fu_stall_o), 32'b1110);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(cdb_vld_o), 32'd0);
    chk("async_rst_tag", 32'(cdb_tag_o), 32'd0);
    chk("async_rst_idx", 32'(cdb_fu_idx_o), 32'd0);
    chk("async_rst_stall", 32'(fu_stall_o), 32'd0);
    #2 rst = 1'b0;
    model_reset();
    step(4'b0000, tg(0,0,0,0), 1'b0);
    chk("post_rst_no_stale", 32'(cdb_vld_o), 32'd0);
    step(4'b0100, tg(0,0,77,0), 1'b0);
    chk("post_rst_single", 32'(cdb_tag_o), 32'd77);

    // Randomized traffic; FUs only fire when the scoreboard says they are free.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] v;
      tags_t      t;
      logic       fl;
      v  = 4'($urandom) & ~m_hold_v;
      t  = tg($urandom_range(127), $urandom_range(127), $urandom_range(127), $urandom_range(127));
      fl = ($urandom_range(15) == 0);
      step(v, t, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
